fp_multiplier_seq: RTL and testbench
====================================

FP_MULTIPLIER_SEQ -- requirements
Module: fp_multiplier_seq

Interface
REQ-001 Parameter n, default 32, total IEEE-754 word width.
REQ-002 Parameter m, default 8, exponent field width; F = n-m-1 fraction bits; bias = 2^(m-1)-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 a  input  n  operand A {sign, exp[m], frac[F]}; captured on the accepting edge.
REQ-007 b  input  n  operand B, same format; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 out  output  n  product a*b; held stable from done until the next done.
REQ-011 ovf  output  1  overflow flag, valid with done, held with out.
REQ-012 unf  output  1  underflow flag, valid with done, held with out.

Function
REQ-013 FSM states are IDLE, MUL and NORM, all registered.
REQ-014 IDLE: start=1 -> capture a and b, set busy=1; go to NORM if either operand is special, else to MUL with iteration counter = 0.
REQ-015 Special operand means exponent field all-zeros (treated as zero, denormals flushed) or all-ones (Inf/NaN).
REQ-016 MUL: radix-2 shift-and-add over the (F+1)-bit significands {1,frac}, one multiplier bit per cycle, into a 2F+2-bit product register.
REQ-017 MUL lasts exactly F+1 cycles, then goes to NORM.
REQ-018 Exponent sum = ea + eb - bias, computed m+2 bits wide, signed.
REQ-019 NORM, product MSB=1: frac = prod[2F:F+1], exponent +1; else frac = prod[2F-1:F].
REQ-020 Rounding is truncation (toward zero); no sticky or guard bits.
REQ-021 Sign = sign_a XOR sign_b for every result except NaN.
REQ-022 Final biased exponent >= 2^m-1 -> out = signed Inf (exp all-ones, frac 0), ovf=1.
REQ-023 Final biased exponent <= 0 -> out = signed zero, unf=1.
REQ-024 Special-result priority: NaN operand, or Inf*zero -> canonical NaN {0, all-ones, 1, zeros}; else Inf operand -> signed Inf; else zero operand -> signed zero; ovf=unf=0 in all these cases.
REQ-025 NORM registers out, ovf and unf, pulses done=1, clears busy, and returns to IDLE in the same edge.
REQ-026 Latency, normal operands: done is high in the cycle after edge k+F+2, where k is the accepting edge (edge k+25 for n=32).
REQ-027 Latency, special operands: done is high in the cycle after edge k+1.
REQ-028 start while busy=1 is ignored; operands are not recaptured.
REQ-029 start asserted in the cycle done is high is accepted (back-to-back operation).

Reset
REQ-030 rst=1 at any edge forces IDLE and sets busy=0, done=0, out=0, ovf=0, unf=0, counter=0, product register=0.
REQ-031 Reset mid-operation aborts the operation; no done is produced for it.
REQ-032 rst has priority over start on the same edge.

Verification
REQ-033 a=0x40000000 (2.0), b=0x40400000 (3.0) -> out=0x40C00000, ovf=unf=0, done in the cycle after edge k+25, busy high until then.
REQ-034 a=b=0x3FC00000 (1.5) -> out=0x40100000 (2.25), exercising the product-MSB normalization path.
REQ-035 a=0xC0000000, b=0x00000000 -> out=0x80000000, done in the cycle after edge k+1; a=0x7F800000, b=0 -> out=0x7FC00000.
REQ-036 a=b=0x7F000000 -> out=0x7F800000, ovf=1; a=b=0x00800000 -> out=0x00000000, unf=1.
REQ-037 Pulse start again 5 cycles into an operation with different operands -> ignored, first result unchanged; start on the done cycle -> second result follows with full latency.
REQ-038 Assert rst 10 cycles into an operation -> busy=0 and out=0 next cycle; no done; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-and-add on the significands,
// truncating rounding, flush-to-zero on denormals, flag-based over/underflow.
module fp_multiplier_seq #(
    parameter int n = 32,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] out,
    output logic         ovf,
    output logic         unf
);

    localparam int F  = n - m - 1;
    localparam int W  = 2 * F + 2;
    localparam int E  = m + 2;
    localparam int CW = $clog2(F + 1);

    localparam logic signed [E-1:0] BIAS = E'((1 << (m - 1)) - 1);
    localparam logic signed [E-1:0] EMAX = E'((1 << m) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM
    } state_t;

    state_t state, state_nx;

    logic [n-1:0]  ra, rb;
    logic [W-1:0]  prod, mcand;
    logic [F:0]    mplier;
    logic [CW-1:0] cnt;

    // operands on the input pins, used to pick the MUL or NORM path
    logic [m-1:0] ea_in, eb_in;
    logic         spec_in;

    assign ea_in   = a[n-2:F];
    assign eb_in   = b[n-2:F];
    assign spec_in = (ea_in == '0) || (&ea_in) ||
                     (eb_in == '0) || (&eb_in);

    // captured operand classification
    logic [m-1:0] ea, eb;
    logic [F-1:0] fa, fb;
    logic         sgn;
    logic         a_zero, a_inf, a_nan;
    logic         b_zero, b_inf, b_nan;

    assign ea  = ra[n-2:F];
    assign eb  = rb[n-2:F];
    assign fa  = ra[F-1:0];
    assign fb  = rb[F-1:0];
    assign sgn = ra[n-1] ^ rb[n-1];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    // only the top F+2 product bits feed the truncated result
    logic unused_bits;
    assign unused_bits = ^prod[F-1:0];

    // result formed while in NORM
    logic                 msb;
    logic signed [E-1:0]  esum, efin;
    logic [F-1:0]         frac_n;
    logic [n-1:0]         res;
    logic                 res_ovf, res_unf;

    // normalize, check exponent range, then apply special-operand priority
    always_comb begin
        msb     = prod[W-1];
        esum    = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS;
        efin    = esum + signed'({{(E-1){1'b0}}, msb});
        frac_n  = msb ? prod[2*F:F+1] : prod[2*F-1:F];
        res     = {sgn, efin[m-1:0], frac_n};
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            res = {1'b0, {m{1'b1}}, 1'b1, {(F-1){1'b0}}};
        end else if (a_inf || b_inf) begin
            res = {sgn, {m{1'b1}}, {F{1'b0}}};
        end else if (a_zero || b_zero) begin
            res = {sgn, {(n-1){1'b0}}};
        end else if (efin >= EMAX) begin
            res     = {sgn, {m{1'b1}}, {F{1'b0}}};
            res_ovf = 1'b1;
        end else if (efin[E-1] || (efin == '0)) begin
            res     = {sgn, {(n-1){1'b0}}};
            res_unf = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = spec_in ? NORM : MUL;
            MUL:  if (cnt == CW'(F)) state_nx = NORM;
            NORM: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy is a pure function of state
    always_comb begin
        busy = (state != IDLE);
    end

    // operand capture, shift-and-add datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra     <= a;
                        rb     <= b;
                        prod   <= '0;
                        cnt    <= '0;
                        mcand  <= {{(F+1){1'b0}}, 1'b1, a[F-1:0]};
                        mplier <= {1'b1, b[F-1:0]};
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                NORM: begin
                    out  <= res;
                    ovf  <= res_ovf;
                    unf  <= res_unf;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Scoreboard bench for fp_multiplier_seq: directed vectors plus random
// operands checked against an arithmetic reference model.
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, ovf, unf;
    logic [31:0] out;

    fp_multiplier_seq #(.n(32), .m(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] out;
        logic        ovf;
        logic        unf;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit is_special(logic [31:0] x, logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    // Reference: classify operands, multiply significands as integers,
    // normalize, truncate, and range-check the biased exponent.
    function automatic exp_t model(logic [31:0] x, logic [31:0] y);
        exp_t        r;
        logic [7:0]  ex = x[30:23];
        logic [7:0]  ey = y[30:23];
        logic [22:0] fx = x[22:0];
        logic [22:0] fy = y[22:0];
        logic        s  = x[31] ^ y[31];
        bit xz = (ex == 0), yz = (ey == 0);
        bit xi = (ex == 255) && (fx == 0), yi = (ey == 255) && (fy == 0);
        bit xn = (ex == 255) && (fx != 0), yn = (ey == 255) && (fy != 0);
        longint      p;
        int          e;
        logic [22:0] fr;
        r.ovf = 0;
        r.unf = 0;
        r.cyc = 0;
        if (xn || yn || (xi && yz) || (xz && yi)) begin
            r.out = 32'h7FC00000;
        end else if (xi || yi) begin
            r.out = {s, 31'h7F800000};
        end else if (xz || yz) begin
            r.out = {s, 31'h0};
        end else begin
            p = longint'({1'b1, fx}) * longint'({1'b1, fy});
            e = int'(ex) + int'(ey) - 127;
            if (p[47]) begin
                fr = p[46:24];
                e++;
            end else begin
                fr = p[45:23];
            end
            if (e >= 255) begin
                r.out = {s, 31'h7F800000};
                r.ovf = 1;
            end else if (e <= 0) begin
                r.out = {s, 31'h0};
                r.unf = 1;
            end else begin
                r.out = {s, e[7:0], fr};
            end
        end
        return r;
    endfunction

    // wait for idle (bounded), present operands for one accepting edge
    task automatic issue(logic [31:0] x, logic [31:0] y, exp_t e);
        int waited = 0;
        while (busy && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (busy) begin
            nvec++;
            nerr++;
            $display("FAIL issue_timeout: busy stuck 1 want 0");
        end
        a     = x;
        b     = y;
        start = 1'b1;
        e.cyc = cyc + 1 + (is_special(x, y) ? 1 : 25);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue_rand(logic [31:0] x, logic [31:0] y);
        issue(x, y, model(x, y));
    endtask

    task automatic issue_dir(logic [31:0] x, logic [31:0] y,
                             logic [31:0] o, logic fo, logic fu);
        exp_t e;
        e.out = o;
        e.ovf = fo;
        e.unf = fu;
        e.cyc = 0;
        issue(x, y, e);
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          c = $urandom_range(0, 9);
        if (c == 0)      ex = 8'h00;
        else if (c == 1) ex = 8'hFF;
        else if (c < 5)  ex = 8'($urandom_range(1, 254));
        else             ex = 8'($urandom_range(90, 164));
        fr = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), ex, fr};
    endfunction

    // monitor: pop on done, otherwise confirm outputs are held
    logic [31:0] hold_out = '0;
    logic        hold_ovf = 1'b0;
    logic        hold_unf = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_out = '0;
            hold_ovf = 1'b0;
            hold_unf = 1'b0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_done: done 1 want 0 out %h", out);
            end else begin
                e = sbq.pop_front();
                chk("result", out, e.out);
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("unf", 32'(unf), 32'(e.unf));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_on_done", 32'(busy), 32'h0);
                hold_out = out;
                hold_ovf = ovf;
                hold_unf = unf;
            end
        end else begin
            chk("held_out", out, hold_out);
            chk("held_flags", {30'h0, ovf, unf}, {30'h0, hold_ovf, hold_unf});
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_out", out, 32'h0);

        // directed vectors
        issue_dir(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0);
        @(negedge clk);
        chk("busy_in_flight", 32'(busy), 32'h1);
        issue_dir(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0);
        issue_dir(32'hC0000000, 32'h00000000, 32'h80000000, 0, 0);
        issue_dir(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0);
        issue_dir(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0);
        issue_dir(32'h00800000, 32'h00800000, 32'h00000000, 0, 1);
        issue_dir(32'hFF800000, 32'h3F800000, 32'hFF800000, 0, 0);
        issue_dir(32'h7FC00001, 32'hFF800000, 32'h7FC00000, 0, 0);

        // start while busy is ignored; next start lands on the done cycle
        issue_dir(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        a     = 32'h41200000;
        b     = 32'h41200000;
        start = 1'b1;
        @(negedge clk);
        chk("busy_ignore", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        start = 1'b0;
        issue_dir(32'h41200000, 32'h41200000, 32'h42C80000, 0, 0);

        // reset ten cycles into an operation
        issue_dir(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_out", out, 32'h0);
        chk("abort_flags", {30'h0, ovf, unf}, 32'h0);
        repeat (30) @(posedge clk);
        #1;
        issue_dir(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0);

        // random operands against the model
        for (int i = 0; i < 300; i++) begin
            issue_rand(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        // drain the scoreboard
        for (int t = 0; t < 200 && sbq.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: pending %0d want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
